// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch front end.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   JAL_OPCODE       : major opcode of the RISC-V JAL instruction
//   fetch_entry_t    : one buffered fetch {pc, inst}
//   fetch_state_t    : fetch FSM encoding
//   j_imm()          : sign-extended J-type immediate of an instruction word
package inst_fetcher_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [6:0]  JAL_OPCODE       = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_STALL = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_fifo.sv
// fetch_fifo: circular buffer of fetched instructions.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : empty the buffer (wins over push/pop)
//   push, wr_data  : write one entry at the tail (ignored when full without pop)
//   pop            : retire the head entry (ignored when empty)
//   rd_data        : head entry, forced to zero while empty
//   count          : number of stored entries
//   full, empty    : occupancy flags
module fetch_fifo
  import inst_fetcher_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t wr_data,
  input  logic         pop,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);

  assign rd_data = empty ? '0 : mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + AW'(1);
      if (rd_en) head <= head + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[tail] <= wr_data;
  end

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: issues sequential fetch requests to the instruction cache and
// buffers returned words for the decoder.
// Optional feature: define FETCH_JAL_PREDICT_EN to redirect fetch to the
// target of an accepted JAL instead of PC+4.
// Ports:
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   rdy_in                  : global ready, low freezes all state
//   rob_clear_up, clear_pc  : flush request and redirect target
//   icache_pc               : fetch address to the cache
//   icache_start_fetch      : fetch request valid
//   icache_hit, icache_inst, icache_inst_addr : cache response
//   dec_valid, dec_inst, dec_pc : buffer head toward the decoder
//   dec_ready               : decoder consumes the head
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] clear_pc,
  output logic [31:0] icache_pc,
  output logic        icache_start_fetch,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  input  logic [31:0] icache_inst_addr,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          hit_ok;
  logic          push;
  logic          pop;
  logic          clear;
  logic [31:0]   pc_next;

  assign clear  = rdy_in && rob_clear_up;
  assign pop    = rdy_in && !rob_clear_up && !empty && dec_ready;
  assign hit_ok = icache_start_fetch && (state == S_FETCH) &&
                  icache_hit && (icache_inst_addr == icache_pc);
  assign push   = rdy_in && !rob_clear_up && hit_ok && (!full || pop);

  assign count_next = count + CW'(push) - CW'(pop);

  assign wr_entry.pc   = icache_pc;
  assign wr_entry.inst = icache_inst;

`ifdef FETCH_JAL_PREDICT_EN
  assign pc_next = (icache_inst[6:0] == JAL_OPCODE) ? icache_pc + j_imm(icache_inst)
                                                    : icache_pc + 32'd4;
`else
  assign pc_next = icache_pc + 32'd4;
`endif

  // Request valid is registered so it drops the cycle after the buffer fills
  // and stays low through reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= S_FETCH;
      icache_pc          <= RESET_PC;
      icache_start_fetch <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        state              <= S_FETCH;
        icache_pc          <= clear_pc;
        icache_start_fetch <= 1'b1;
      end else begin
        if (push) icache_pc <= pc_next;
        if (count_next == CW'(FIFO_DEPTH)) begin
          state              <= S_STALL;
          icache_start_fetch <= 1'b0;
        end else begin
          state              <= S_FETCH;
          icache_start_fetch <= 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .clear   (clear),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign dec_valid = !empty;
  assign dec_inst  = head_entry.inst;
  assign dec_pc    = head_entry.pc;

endmodule
